// File: rtl/prils_pkg.sv
// Shared definitions for the prils normalization sequencer.
// Provides the prils controller command codes, the sequencer state
// encoding, the default width of the accumulated shift count, and a
// helper that picks the priority-encode command for a given precision.
package prils_pkg;

  localparam int CNT_W_DEF = 7;

  // Commands to the prils controller. Code 5 is never issued.
  localparam logic [2:0] PF_NOP    = 3'd0;
  localparam logic [2:0] PF_PENC_S = 3'd1;
  localparam logic [2:0] PF_PENC_D = 3'd2;
  localparam logic [2:0] PF_LSH_N  = 3'd3;
  localparam logic [2:0] PF_LSH_32 = 3'd4;
  localparam logic [2:0] PF_CLR    = 3'd6;
  localparam logic [2:0] PF_LOAD   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ENC  = 3'd2,
    ST_SH32 = 3'd3,
    ST_SHN  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic logic [2:0] penc_code(input logic dprec);
    return dprec ? PF_PENC_D : PF_PENC_S;
  endfunction

endpackage

// File: rtl/prils_shacc.sv
// Saturating shift accumulator and pass counter.
// Ports:
//   clk_i, reset_i  clock, async active-high reset
//   hold_i          freeze both counters
//   clr_i           clear both counters (wins over add_i)
//   add_i           add add_amt_i to the total and count one pass
//   add_amt_i       shift amount of the pass just completed (0..32)
//   total_o         accumulated shift, saturates at all-ones
//   pass_o          number of completed passes, saturates at all-ones
module prils_shacc
  import prils_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PASS_W = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              hold_i,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [5:0]        add_amt_i,
  output logic [CNT_W-1:0]  total_o,
  output logic [PASS_W-1:0] pass_o
);

  logic [CNT_W-1:0]  total_q, total_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [CNT_W:0]    sum;

  always_comb begin
    // One extra bit catches the carry that triggers saturation.
    sum     = {1'b0, total_q} + {{(CNT_W-5){1'b0}}, add_amt_i};
    total_d = total_q;
    pass_d  = pass_q;
    if (clr_i) begin
      total_d = '0;
      pass_d  = '0;
    end else if (add_i) begin
      total_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      if (pass_q != '1) pass_d = pass_q + PASS_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      total_q <= '0;
      pass_q  <= '0;
    end else if (!hold_i) begin
      total_q <= total_d;
      pass_q  <= pass_d;
    end
  end

  assign total_o = total_q;
  assign pass_o  = pass_q;

endmodule

// File: rtl/prils_norm_seq.sv
// Normalization sequencer for the prils priority-encode / left-shift path.
// Loads the mantissa, alternates priority-encode and shift commands until
// the leading-zero count reads zero, and reports the total left shift.
// Ports:
//   clk_i, reset_i   clock, async active-high reset
//   fpuhold_i        global stall, freezes all state and outputs
//   start_i          begin an operation (accepted only in IDLE)
//   dprec_i          1 = double precision, sampled with start
//   zero_in_i        mantissa is zero, sampled with start
//   lz_cnt_i         leading-zero count, valid in the ENC cycle
//   prifunc_o        command to the prils controller
//   shamt_o          shift amount accompanying LSH_N
//   busy_o           operation in progress (through DONE)
//   done_o           one-cycle completion pulse
//   shift_total_o    accumulated left shift, held until next start
//   zero_out_o       result is zero
//   err_o            pass limit exceeded or illegal single-precision count
//
// state | meaning
// IDLE  | waiting for start, prifunc = NOP
// LOAD  | mantissa load command issued
// ENC   | priority encode issued, lz_cnt examined at end of cycle
// SH32  | shift by 32 issued
// SHN   | shift by shamt issued
// DONE  | clear issued, done pulse
module prils_norm_seq
  import prils_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_PASS = 3,
  parameter int SP_MAXLZ = 23
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             fpuhold_i,
  input  logic             start_i,
  input  logic             dprec_i,
  input  logic             zero_in_i,
  input  logic [5:0]       lz_cnt_i,
  output logic [2:0]       prifunc_o,
  output logic [4:0]       shamt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] shift_total_o,
  output logic             zero_out_o,
  output logic             err_o
);

  localparam int PASS_W = $clog2(MAX_PASS + 1);
  localparam logic [PASS_W-1:0] MAX_PASS_V = PASS_W'(MAX_PASS);
  localparam logic [5:0]        SP_MAXLZ_V = 6'(SP_MAXLZ);

  state_e            state_q;
  logic [2:0]        prifunc_q;
  logic [4:0]        shamt_q;
  logic              busy_q;
  logic              done_q;
  logic              zero_q;
  logic              err_q;
  logic              dprec_q;
  logic [PASS_W-1:0] pass_cnt;
  logic              acc_clr;
  logic              acc_add;
  logic [5:0]        acc_amt;

  // The shift of a pass is credited at the end of its SH32/SHN cycle.
  assign acc_clr = (state_q == ST_IDLE) && start_i;
  assign acc_add = (state_q == ST_SH32) || (state_q == ST_SHN);
  assign acc_amt = (state_q == ST_SH32) ? 6'd32 : {1'b0, shamt_q};

  prils_shacc #(
    .CNT_W  (CNT_W),
    .PASS_W (PASS_W)
  ) u_shacc (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .hold_i    (fpuhold_i),
    .clr_i     (acc_clr),
    .add_i     (acc_add),
    .add_amt_i (acc_amt),
    .total_o   (shift_total_o),
    .pass_o    (pass_cnt)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      prifunc_q <= PF_NOP;
      shamt_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
      dprec_q   <= 1'b0;
    end else if (!fpuhold_i) begin
      done_q  <= 1'b0;
      shamt_q <= '0;
      case (state_q)
        ST_IDLE: begin
          prifunc_q <= PF_NOP;
          if (start_i) begin
            dprec_q <= dprec_i;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            if (zero_in_i) begin
              state_q   <= ST_DONE;
              prifunc_q <= PF_CLR;
              done_q    <= 1'b1;
              zero_q    <= 1'b1;
            end else begin
              state_q   <= ST_LOAD;
              prifunc_q <= PF_LOAD;
              zero_q    <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          state_q   <= ST_ENC;
          prifunc_q <= penc_code(dprec_q);
        end
        ST_ENC: begin
          if (lz_cnt_i == '0) begin
            state_q   <= ST_DONE;
            prifunc_q <= PF_CLR;
            done_q    <= 1'b1;
          end else if ((!dprec_q && (lz_cnt_i > SP_MAXLZ_V)) ||
                       (pass_cnt == MAX_PASS_V)) begin
            state_q   <= ST_DONE;
            prifunc_q <= PF_CLR;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
          end else if (lz_cnt_i[5]) begin
            state_q   <= ST_SH32;
            prifunc_q <= PF_LSH_32;
          end else begin
            state_q   <= ST_SHN;
            prifunc_q <= PF_LSH_N;
            shamt_q   <= lz_cnt_i[4:0];
          end
        end
        ST_SH32, ST_SHN: begin
          state_q   <= ST_ENC;
          prifunc_q <= penc_code(dprec_q);
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          prifunc_q <= PF_NOP;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          prifunc_q <= PF_NOP;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign prifunc_o  = prifunc_q;
  assign shamt_o    = shamt_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign zero_out_o = zero_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_prils_norm_seq.sv
module tb_prils_norm_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       fpuhold;
  logic       start;
  logic       dprec;
  logic       zero_in;
  logic [5:0] lz_cnt;
  logic [2:0] prifunc;
  logic [4:0] shamt;
  logic       busy;
  logic       done;
  logic [6:0] shift_total;
  logic       zero_out;
  logic       err;

  always #5 clk = ~clk;

  prils_norm_seq dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .fpuhold_i     (fpuhold),
    .start_i       (start),
    .dprec_i       (dprec),
    .zero_in_i     (zero_in),
    .lz_cnt_i      (lz_cnt),
    .prifunc_o     (prifunc),
    .shamt_o       (shamt),
    .busy_o        (busy),
    .done_o        (done),
    .shift_total_o (shift_total),
    .zero_out_o    (zero_out),
    .err_o         (err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Expected per-cycle timeline of one operation (index 0 = first cycle
  // after the start edge). lz = -1 / sh = -1 mean "not applicable".
  int exp_pf[$];
  int exp_lz[$];
  int exp_sh[$];
  int exp_tot[$];

  task automatic push_cyc(input int pf, input int lz, input int sh, input int tot);
    exp_pf.push_back(pf);
    exp_lz.push_back(lz);
    exp_sh.push_back(sh);
    exp_tot.push_back(tot);
  endtask

  // Command-level reference: LOAD, then encode/shift rounds, then CLR.
  task automatic build_model(input bit dp, input bit zr, input int lzs[4],
                             output int fin_tot, output bit fin_err);
    int tot;
    int passes;
    exp_pf.delete(); exp_lz.delete(); exp_sh.delete(); exp_tot.delete();
    fin_err = 1'b0;
    tot = 0;
    passes = 0;
    if (zr) begin
      push_cyc(6, -1, -1, 0);
    end else begin
      push_cyc(7, -1, -1, 0);
      for (int k = 0; k < 4; k++) begin
        push_cyc(dp ? 2 : 1, lzs[k], -1, tot);
        if (lzs[k] == 0) break;
        if (!dp && lzs[k] > 23) begin fin_err = 1'b1; break; end
        if (passes == 3) begin fin_err = 1'b1; break; end
        if (lzs[k] >= 32) begin
          push_cyc(4, -1, -1, tot);
          tot = tot + 32;
        end else begin
          push_cyc(3, -1, lzs[k], tot);
          tot = tot + lzs[k];
        end
        if (tot > 127) tot = 127;
        passes++;
      end
      push_cyc(6, -1, -1, tot);
    end
    fin_tot = tot;
  endtask

  task automatic check_cycle(input string nm, input int i, input int last,
                             input bit zr, input bit fin_err);
    bit is_last;
    is_last = (i == last);
    check_val($sformatf("%s.pf%0d", nm, i), prifunc, exp_pf[i]);
    check_val($sformatf("%s.busy%0d", nm, i), busy, 1);
    check_val($sformatf("%s.done%0d", nm, i), done, is_last);
    check_val($sformatf("%s.tot%0d", nm, i), shift_total, exp_tot[i]);
    check_val($sformatf("%s.err%0d", nm, i), err, is_last ? fin_err : 1'b0);
    check_val($sformatf("%s.zero%0d", nm, i), zero_out, is_last ? zr : 1'b0);
    if (exp_sh[i] >= 0) check_val($sformatf("%s.shamt%0d", nm, i), shamt, exp_sh[i]);
  endtask

  task automatic run_op(input string nm, input bit dp, input bit zr, input int lzs[4],
                        input int hold_at, input int hold_len);
    int fin_tot;
    bit fin_err;
    int last;
    build_model(dp, zr, lzs, fin_tot, fin_err);
    last = exp_pf.size() - 1;
    @(negedge clk);
    start = 1'b1; dprec = dp; zero_in = zr; lz_cnt = 6'($urandom);
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      // Inputs other than lz in ENC are don't-care while busy.
      start   = (i == last) ? 1'b0 : 1'($urandom);
      dprec   = 1'($urandom);
      zero_in = 1'($urandom);
      lz_cnt  = (exp_lz[i] >= 0) ? 6'(exp_lz[i]) : 6'($urandom);
      check_cycle(nm, i, last, zr, fin_err);
      if (i == hold_at) begin
        fpuhold = 1'b1;
        repeat (hold_len) begin
          @(negedge clk);
          check_cycle({nm, ".hold"}, i, last, zr, fin_err);
        end
        fpuhold = 1'b0;
      end
    end
    @(negedge clk);
    check_val({nm, ".idle_pf"}, prifunc, 0);
    check_val({nm, ".idle_busy"}, busy, 0);
    check_val({nm, ".idle_done"}, done, 0);
    check_val({nm, ".held_tot"}, shift_total, fin_tot);
    check_val({nm, ".held_err"}, err, fin_err);
    check_val({nm, ".held_zero"}, zero_out, zr);
  endtask

  task automatic check_all_zero(input string nm);
    check_val({nm, ".pf"}, prifunc, 0);
    check_val({nm, ".shamt"}, shamt, 0);
    check_val({nm, ".busy"}, busy, 0);
    check_val({nm, ".done"}, done, 0);
    check_val({nm, ".tot"}, shift_total, 0);
    check_val({nm, ".zero"}, zero_out, 0);
    check_val({nm, ".err"}, err, 0);
  endtask

  function automatic int rand_lz();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 0;
    if (r < 5) return $urandom_range(32, 63);
    if (r < 6) return $urandom_range(24, 31);
    return $urandom_range(1, 23);
  endfunction

  int lzv[4];

  initial begin
    reset = 1'b1; fpuhold = 1'b0; start = 1'b0; dprec = 1'b0; zero_in = 1'b0; lz_cnt = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Start under hold in IDLE must not be accepted or queued.
    @(negedge clk);
    start = 1'b1; fpuhold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("hold_idle.busy", busy, 0);
      check_val("hold_idle.pf", prifunc, 0);
    end
    start = 1'b0; fpuhold = 1'b0;
    @(negedge clk);
    check_val("hold_idle.noqueue", busy, 0);

    lzv = '{0, 0, 0, 0};   run_op("norm",    1'b1, 1'b0, lzv, -1, 0);
    lzv = '{5, 0, 0, 0};   run_op("single",  1'b0, 1'b0, lzv, -1, 0);
    lzv = '{40, 8, 0, 0};  run_op("wide",    1'b1, 1'b0, lzv, -1, 0);
    lzv = '{0, 0, 0, 0};   run_op("zero",    1'b0, 1'b1, lzv, -1, 0);
    lzv = '{30, 0, 0, 0};  run_op("sp_ill",  1'b0, 1'b0, lzv, -1, 0);
    lzv = '{24, 0, 0, 0};  run_op("sp_24",   1'b0, 1'b0, lzv, -1, 0);
    lzv = '{23, 0, 0, 0};  run_op("sp_23",   1'b0, 1'b0, lzv, -1, 0);
    lzv = '{1, 1, 1, 1};   run_op("passlim", 1'b0, 1'b0, lzv, -1, 0);
    lzv = '{1, 1, 1, 0};   run_op("pass3ok", 1'b1, 1'b0, lzv, -1, 0);
    lzv = '{32, 63, 31, 1}; run_op("dp_big", 1'b1, 1'b0, lzv, -1, 0);
    lzv = '{5, 0, 0, 0};   run_op("hold_shn",  1'b0, 1'b0, lzv, 2, 4);
    lzv = '{0, 0, 0, 0};   run_op("hold_done", 1'b1, 1'b0, lzv, 2, 2);

    for (int n = 0; n < 60; n++) begin
      bit dp;
      bit zr;
      int hat;
      dp = 1'($urandom);
      zr = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 4; k++) lzv[k] = rand_lz();
      hat = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 8);
      run_op($sformatf("rnd%0d", n), dp, zr, lzv, hat, $urandom_range(1, 4));
    end

    // Asynchronous reset in the second ENC cycle, after one shift of 5.
    @(negedge clk);
    start = 1'b1; dprec = 1'b0; zero_in = 1'b0;
    @(negedge clk);                   // LOAD
    start = 1'b0;
    @(negedge clk);                   // ENC
    lz_cnt = 6'd5;
    @(negedge clk);                   // SHN
    lz_cnt = 6'd9;
    @(posedge clk);                   // now in ENC
    #2 reset = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    lzv = '{9, 0, 0, 0};  run_op("after_rst", 1'b0, 1'b0, lzv, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
